// File: rtl/music_recorder_pkg.sv
// Shared parameters and FSM encoding for the music recorder.
//   DATA_WIDTH    : default one-hot note/octave word width
//   MAX_DEPTH_BIT : log2 of the default number of note slots
//   DEF_DEPTH     : default number of note slots
//   rec_state_e   : recorder FSM state encoding
package music_recorder_pkg;

  localparam int DATA_WIDTH    = 10;
  localparam int MAX_DEPTH_BIT = 5;
  localparam int DEF_DEPTH     = 1 << MAX_DEPTH_BIT;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_FULL   = 2'd2
  } rec_state_e;

endpackage

// File: rtl/music_recorder_if.sv
// Control/data bundle between a keyboard/player controller and the recorder.
//   master : drives rec_start, rec_stop, clear, note_in, read_en, read_rst
//   slave  : drives data_out, output_ready, count, duration, recording,
//            full and the FSM state (debug)
// Handshake: read_en is a level request from the consumer; the recorder
// presents data_out qualified by output_ready (valid). There is no
// back-pressure: a slot is shown for SAMPLE_INTERVAL cycles while read_en
// stays high, and read_en low freezes playback where it is.
interface music_recorder_if #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 32
);
  import music_recorder_pkg::rec_state_e;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  rec_start;
  logic                  rec_stop;
  logic                  clear;
  logic [DATA_WIDTH-1:0] note_in;
  logic                  read_en;
  logic                  read_rst;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  output_ready;
  logic [CW-1:0]         count;
  logic [CW+2:0]         duration;
  logic                  recording;
  logic                  full;
  rec_state_e            state;

  modport master (
    output rec_start, rec_stop, clear, note_in, read_en, read_rst,
    input  data_out, output_ready, count, duration, recording, full, state
  );

  modport slave (
    input  rec_start, rec_stop, clear, note_in, read_en, read_rst,
    output data_out, output_ready, count, duration, recording, full, state
  );

endinterface

// File: rtl/music_recorder_interval_timer.sv
// Module interval_timer: counts 1..INTERVAL and flags the last count.
//   clk, rst_n : clock, synchronous active-low reset (counter -> 1)
//   load       : force the counter back to 1 (wins over en)
//   en         : advance the counter; wraps to 1 after INTERVAL
//   tick       : high while the counter equals INTERVAL
module interval_timer #(
  parameter int INTERVAL = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(INTERVAL + 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(INTERVAL));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= CW'(1);
    end else if (load) begin
      cnt <= CW'(1);
    end else if (en) begin
      if (tick) cnt <= CW'(1);
      else      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/music_recorder.sv
// Music recorder: samples note_in once every SAMPLE_INTERVAL cycles into a
// DEPTH-slot memory while recording, then plays the captured slots back at
// the same rate.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : music_recorder_if slave (controls, note_in, playback data,
//                status: count, duration, recording, full, state)
module music_recorder #(
  parameter int DATA_WIDTH      = music_recorder_pkg::DATA_WIDTH,
  parameter int DEPTH           = music_recorder_pkg::DEF_DEPTH,
  parameter int SAMPLE_INTERVAL = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  music_recorder_if.slave   bus
);
  import music_recorder_pkg::rec_state_e;
  import music_recorder_pkg::ST_IDLE;
  import music_recorder_pkg::ST_RECORD;
  import music_recorder_pkg::ST_FULL;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rec_state_e            state;
  logic [CW-1:0]         count;
  logic [AW-1:0]         wr_ptr;
  logic [CW-1:0]         rd_ptr;   // may equal count (== DEPTH when full)
  logic                  output_ready;
  logic [DATA_WIDTH-1:0] data_out;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rd;

  logic wr_tick, rd_tick;
  logic wr_load, wr_cnt_en, wr_en;
  logic rd_load, rd_cnt_en;
  logic playback_ok;

  // clear and rec_start share the "start over" path, clear taking priority
  // later in the FSM; either one reloads both timers.
  always_comb begin
    playback_ok = 1'b0;
    wr_load     = 1'b0;
    wr_cnt_en   = 1'b0;
    wr_en       = 1'b0;
    rd_load     = 1'b0;
    rd_cnt_en   = 1'b0;

    playback_ok = (state != ST_RECORD) && bus.read_en && (rd_ptr < count);

    wr_load   = bus.clear || bus.rec_start;
    // A stop pulse beats a coincident tick, so the timer must not wrap
    // and the slot must not be written in that cycle.
    wr_cnt_en = (state == ST_RECORD) && !bus.rec_stop;
    wr_en     = rst_n && !wr_load && wr_cnt_en && wr_tick;

    rd_load   = bus.clear || bus.rec_start || bus.read_rst;
    rd_cnt_en = playback_ok;
  end

  interval_timer #(.INTERVAL(SAMPLE_INTERVAL)) u_wr_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (wr_load),
    .en    (wr_cnt_en),
    .tick  (wr_tick)
  );

  interval_timer #(.INTERVAL(SAMPLE_INTERVAL)) u_rd_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (rd_load),
    .en    (rd_cnt_en),
    .tick  (rd_tick)
  );

  // Note memory: no reset, slots beyond count are never presented.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.note_in;
  end

  assign mem_rd = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      output_ready <= 1'b0;
      data_out     <= '0;
    end else if (bus.clear) begin
      state        <= ST_IDLE;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      output_ready <= 1'b0;
    end else if (bus.rec_start) begin
      state        <= ST_RECORD;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      output_ready <= 1'b0;
    end else begin
      case (state)
        ST_RECORD: begin
          output_ready <= 1'b0;
          if (bus.rec_stop) begin
            state <= ST_IDLE;
          end else if (wr_tick) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + CW'(1);
            if (count == CW'(DEPTH - 1)) state <= ST_FULL;
          end
        end
        default: begin
          // IDLE and FULL: playback
          if (bus.read_rst) begin
            rd_ptr       <= '0;
            output_ready <= 1'b0;
          end else if (bus.read_en) begin
            if (playback_ok) begin
              output_ready <= 1'b1;
              data_out     <= mem_rd;
              if (rd_tick) rd_ptr <= rd_ptr + CW'(1);
            end else begin
              output_ready <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.data_out     = data_out;
  assign bus.output_ready = output_ready;
  assign bus.count        = count;
  assign bus.duration     = {count, 3'b000};
  assign bus.recording    = (state == ST_RECORD);
  assign bus.full         = (state == ST_FULL);
  assign bus.state        = state;

endmodule

// File: tb/tb_music_recorder.sv
// Directed bench for music_recorder with SAMPLE_INTERVAL = 4, DEPTH = 32.
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// i.e. they reflect the edge just taken.
module tb_music_recorder;

  localparam int DW  = 10;
  localparam int DEP = 32;
  localparam int SI  = 4;

  localparam logic [31:0] S_IDLE   = 32'd0;
  localparam logic [31:0] S_RECORD = 32'd1;
  localparam logic [31:0] S_FULL   = 32'd2;

  logic clk;
  logic rst_n;

  int total_checks;
  int passed_checks;

  music_recorder_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) bus ();

  music_recorder #(
    .DATA_WIDTH      (DW),
    .DEPTH           (DEP),
    .SAMPLE_INTERVAL (SI)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rec_start = 1'b0;
    bus.rec_stop  = 1'b0;
    bus.clear     = 1'b0;
    bus.read_en   = 1'b0;
    bus.read_rst  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    idle_inputs();
    bus.note_in = '0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;

    // reset state
    check("rst_count",    32'(bus.count), 32'd0);
    check("rst_state",    32'(bus.state), S_IDLE);
    check("rst_ready",    32'(bus.output_ready), 32'd0);
    check("rst_data",     32'(bus.data_out), 32'd0);
    check("rst_rec_full", {30'd0, bus.recording, bus.full}, 32'd0);
    check("rst_duration", 32'(bus.duration), 32'd0);

    // three samples then stop
    bus.note_in = 10'b0000000100;
    bus.rec_start = 1'b1;
    step(1);
    bus.rec_start = 1'b0;
    check("t1_recording", 32'(bus.recording), 32'd1);
    check("t1_count0",    32'(bus.count), 32'd0);
    step(3);
    check("t1_first_write_not_early", 32'(bus.count), 32'd0);
    step(1);
    check("t1_first_write", 32'(bus.count), 32'd1);
    step(8);
    check("t1_count3", 32'(bus.count), 32'd3);
    bus.rec_stop = 1'b1;
    step(1);
    bus.rec_stop = 1'b0;
    check("t1_recording_fell", 32'(bus.recording), 32'd0);
    check("t1_count_kept",     32'(bus.count), 32'd3);
    check("t1_duration",       32'(bus.duration), 32'd24);

    // record A, B, C and play back
    bus.note_in = 10'h001;
    bus.rec_start = 1'b1;
    step(1);
    bus.rec_start = 1'b0;
    step(4);
    bus.note_in = 10'h020;
    step(4);
    bus.note_in = 10'h200;
    step(4);
    bus.rec_stop = 1'b1;
    step(1);
    bus.rec_stop = 1'b0;
    check("t2_count",  32'(bus.count), 32'd3);
    check("t2_state",  32'(bus.state), S_IDLE);
    check("t2_ready0", 32'(bus.output_ready), 32'd0);
    bus.read_en = 1'b1;
    step(1);
    check("t2_ready_rise", 32'(bus.output_ready), 32'd1);
    check("t2_slot0",      32'(bus.data_out), 32'h001);
    step(3);
    check("t2_slot0_hold", 32'(bus.data_out), 32'h001);
    step(1);
    check("t2_slot1",      32'(bus.data_out), 32'h020);
    step(4);
    check("t2_slot2",      32'(bus.data_out), 32'h200);
    step(3);
    check("t2_ready_end_not_early", 32'(bus.output_ready), 32'd1);
    step(1);
    check("t2_ready_end",  32'(bus.output_ready), 32'd0);
    step(3);
    check("t2_no_wrap",    32'(bus.output_ready), 32'd0);

    // rewind, replay, rewind mid-playback, freeze
    bus.read_rst = 1'b1;
    step(1);
    bus.read_rst = 1'b0;
    check("t3_rst_ready0", 32'(bus.output_ready), 32'd0);
    step(1);
    check("t3_replay_slot0", 32'(bus.data_out), 32'h001);
    step(5);
    check("t3_mid_slot1", 32'(bus.data_out), 32'h020);
    bus.read_rst = 1'b1;
    step(1);
    bus.read_rst = 1'b0;
    check("t3_mid_rst_ready0", 32'(bus.output_ready), 32'd0);
    check("t3_count_kept",     32'(bus.count), 32'd3);
    step(1);
    check("t3_restart_ready", 32'(bus.output_ready), 32'd1);
    check("t3_restart_slot0", 32'(bus.data_out), 32'h001);
    bus.read_en = 1'b0;
    step(6);
    check("t3_freeze_data",  32'(bus.data_out), 32'h001);
    check("t3_freeze_ready", 32'(bus.output_ready), 32'd1);
    bus.read_en = 1'b1;
    step(3);
    check("t3_resume_slot0", 32'(bus.data_out), 32'h001);
    step(1);
    check("t3_resume_slot1", 32'(bus.data_out), 32'h020);

    // clear beats rec_start
    bus.clear = 1'b1;
    bus.rec_start = 1'b1;
    step(1);
    bus.clear = 1'b0;
    bus.rec_start = 1'b0;
    check("t4_state", 32'(bus.state), S_IDLE);
    check("t4_count", 32'(bus.count), 32'd0);
    check("t4_ready", 32'(bus.output_ready), 32'd0);
    step(2);
    check("t4_empty_read", 32'(bus.output_ready), 32'd0);
    bus.read_en = 1'b0;

    // stop coincident with the 2nd sample tick
    bus.note_in = 10'h010;
    bus.rec_start = 1'b1;
    step(1);
    bus.rec_start = 1'b0;
    step(4);
    check("t5_count1", 32'(bus.count), 32'd1);
    step(3);
    bus.rec_stop = 1'b1;
    step(1);
    bus.rec_stop = 1'b0;
    check("t5_stop_prio_count", 32'(bus.count), 32'd1);
    check("t5_stop_state",      32'(bus.state), S_IDLE);

    // fill all 32 slots
    bus.note_in = 10'h008;
    bus.rec_start = 1'b1;
    step(1);
    bus.rec_start = 1'b0;
    step(124);
    check("t6_count31", 32'(bus.count), 32'd31);
    bus.note_in = 10'h040;
    step(3);
    check("t6_not_full_yet", 32'(bus.full), 32'd0);
    step(1);
    check("t6_count32",  32'(bus.count), 32'd32);
    check("t6_full",     32'(bus.state), S_FULL);
    check("t6_duration", 32'(bus.duration), 32'd256);
    bus.rec_stop = 1'b1;
    step(1);
    bus.rec_stop = 1'b0;
    check("t6_stop_ignored_full", 32'(bus.full), 32'd1);
    bus.note_in = 10'h100;
    step(12);
    check("t6_count_sat", 32'(bus.count), 32'd32);
    bus.read_en = 1'b1;
    step(1);
    check("t6_slot0", 32'(bus.data_out), 32'h008);
    step(123);
    check("t6_slot30", 32'(bus.data_out), 32'h008);
    step(1);
    check("t6_slot31", 32'(bus.data_out), 32'h040);
    step(4);
    check("t6_full_end_ready", 32'(bus.output_ready), 32'd0);
    check("t6_full_end_data",  32'(bus.data_out), 32'h040);
    bus.read_en = 1'b0;

    // reset mid-RECORD
    bus.note_in = 10'h002;
    bus.rec_start = 1'b1;
    step(1);
    bus.rec_start = 1'b0;
    step(20);
    check("t7_count5", 32'(bus.count), 32'd5);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("t7_rst_count", 32'(bus.count), 32'd0);
    check("t7_rst_state", 32'(bus.state), S_IDLE);
    check("t7_rst_ready", 32'(bus.output_ready), 32'd0);
    check("t7_rst_data",  32'(bus.data_out), 32'd0);

    // timer was reset to 1: first write again 4 cycles after rec_start
    bus.rec_start = 1'b1;
    step(1);
    bus.rec_start = 1'b0;
    step(3);
    check("t7_restart_not_early", 32'(bus.count), 32'd0);
    step(1);
    check("t7_restart_write", 32'(bus.count), 32'd1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/music_recorder.md
MUSIC_RECORDER -- requirements
Module: music_recorder

Interface
REQ-001 Parameter DATA_WIDTH, default 10, meaning one-hot note/octave word width.
REQ-002 Parameter DEPTH, default 32, meaning number of storable note slots.
REQ-003 Parameter SAMPLE_INTERVAL, default 50000000, meaning clk cycles per recorded or played slot.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 rec_start  input  1  single-cycle pulse; begin a new recording.
REQ-007 rec_stop  input  1  single-cycle pulse; end recording and keep captured slots.
REQ-008 clear  input  1  discard all recorded content.
REQ-009 note_in  input  DATA_WIDTH  live keyboard note word, sampled while recording.
REQ-010 read_en  input  1  level; play back recorded slots.
REQ-011 read_rst  input  1  rewind playback to slot 0.
REQ-012 data_out  output  DATA_WIDTH  current playback slot.
REQ-013 output_ready  output  1  data_out valid.
REQ-014 count  output  clog2(DEPTH)+1  slots recorded.
REQ-015 duration  output  clog2(DEPTH)+4  count*8, combinational.
REQ-016 recording  output  1  high in state RECORD.
REQ-017 full  output  1  high in state FULL.

Function
REQ-018 FSM states IDLE, RECORD, FULL; recording/full SHALL be decoded from state only.
REQ-019 IDLE + rec_start -> RECORD next cycle; count, wr_ptr, rd_ptr reset to 0; sample counter set to 1.
REQ-020 In RECORD the sample counter SHALL increment each cycle; when it equals SAMPLE_INTERVAL, note_in SHALL be written to mem[wr_ptr], wr_ptr and count incremented, counter reloaded to 1.
REQ-021 First write SHALL occur SAMPLE_INTERVAL cycles after the cycle rec_start was sampled.
REQ-022 Write raising count to DEPTH SHALL move RECORD -> FULL in the same edge; no further writes.
REQ-023 RECORD + rec_stop -> IDLE; rec_stop SHALL take priority over a coincident sample tick (tick not written).
REQ-024 rec_start in RECORD or FULL SHALL restart recording as in REQ-019; rec_stop in IDLE or FULL SHALL be ignored.
REQ-025 clear SHALL force IDLE with count, wr_ptr, rd_ptr = 0, output_ready = 0; clear overrides rec_start/rec_stop in the same cycle.
REQ-026 Playback only in IDLE or FULL: with read_en high and rd_ptr < count, output_ready = 1 and data_out = mem[rd_ptr], registered (1-cycle latency); read counter increments, rd_ptr advances and counter reloads to 1 on reaching SAMPLE_INTERVAL.
REQ-027 rd_ptr == count (including count == 0) SHALL drive output_ready = 0; rd_ptr SHALL NOT wrap.
REQ-028 read_en low SHALL freeze rd_ptr, read counter, data_out, output_ready.
REQ-029 In RECORD output_ready SHALL be 0 and read_en ignored.
REQ-030 read_rst SHALL set rd_ptr = 0, read counter = 1, output_ready = 0; it SHALL NOT affect recorded content or count.
REQ-031 count SHALL saturate at DEPTH; duration SHALL be wide enough for DEPTH*8 without truncation.

Reset
REQ-032 rst_n low at a clock edge: state IDLE, count 0, wr_ptr 0, rd_ptr 0, both counters 1, output_ready 0, data_out 0.
REQ-033 Memory array contents SHALL NOT be reset; unread slots are unreachable since count = 0.
REQ-034 Reset mid-RECORD or mid-playback SHALL discard in-progress slot and take effect next edge.

Structure
REQ-035 DATA_WIDTH, MAX_DEPTH_BIT and the FSM state encoding SHALL live in the shared memory parameter package.
REQ-036 One sub-module, interval_timer (load-to-1, enable, tick at SAMPLE_INTERVAL), SHALL be instantiated twice: write side and read side.
REQ-037 Memory SHALL be a DEPTH x DATA_WIDTH register array with single write port and single read port.

Verification (SAMPLE_INTERVAL = 4, DEPTH = 32)
REQ-038 rec_start, note_in = 10'b0000000100 held 12 cycles, rec_stop -> count = 3, duration = 24, recording falls next edge.
REQ-039 Record notes A,B,C (one per interval), stop, read_en high -> output_ready rises 1 cycle later, data_out A,B,C each 4 cycles, then output_ready = 0.
REQ-040 Record 140 cycles -> count = 32 at cycle 128, full = 1, later note_in changes not stored, duration = 256.
REQ-041 rec_stop on the same cycle as 2nd sample tick -> count = 1.
REQ-042 Mid-playback read_rst -> output_ready 0 next cycle, replay restarts at slot 0; clear with rec_start same cycle -> IDLE, count = 0.
REQ-043 rst_n low during RECORD with count = 5 -> next edge count = 0, state IDLE, output_ready = 0.
